// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states, ALU and immediate selects.
// Pure definitions; no timing or flow control of its own.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_R     = 3'b000;
  localparam logic [2:0] ALU_LUI   = 3'b001;
  localparam logic [2:0] ALU_BR    = 3'b010;
  localparam logic [2:0] ALU_JMP   = 3'b011;
  localparam logic [2:0] ALU_AUIPC = 3'b100;
  localparam logic [2:0] ALU_I     = 3'b101;
  localparam logic [2:0] ALU_MEM   = 3'b110;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_SB = 3'b010;
  localparam logic [2:0] IMM_U  = 3'b011;
  localparam logic [2:0] IMM_UJ = 3'b100;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [2:0] imm_select;
    logic       alu_src;
    logic       alu_pc;
    logic       add_sum_reg;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_nop;
    logic       is_illegal;
  } dec_t;

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_NOP, OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: is_known_op = 1'b1;
      default:                                      is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode into EXEC-stage datapath controls and instruction class flags.
// Zero latency; no flow control.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_R: dec.alu_op = ALU_R;
      OP_I: begin
        dec.alu_op     = ALU_I;
        dec.imm_select = IMM_I;
        dec.alu_src    = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_op     = ALU_MEM;
        dec.imm_select = IMM_I;
        dec.alu_src    = 1'b1;
        dec.is_load    = 1'b1;
      end
      OP_STORE: begin
        dec.alu_op     = ALU_MEM;
        dec.imm_select = IMM_S;
        dec.alu_src    = 1'b1;
        dec.is_store   = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_op     = ALU_BR;
        dec.imm_select = IMM_SB;
        dec.is_branch  = 1'b1;
      end
      OP_JAL: begin
        dec.alu_op     = ALU_JMP;
        dec.imm_select = IMM_UJ;
        dec.alu_pc     = 1'b1;
        dec.is_jump    = 1'b1;
      end
      // jalr targets rs1+imm, hence the sum-from-register select
      OP_JALR: begin
        dec.alu_op      = ALU_JMP;
        dec.imm_select  = IMM_I;
        dec.alu_pc      = 1'b1;
        dec.add_sum_reg = 1'b1;
        dec.is_jump     = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op     = ALU_LUI;
        dec.imm_select = IMM_U;
        dec.alu_src    = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_op     = ALU_AUIPC;
        dec.imm_select = IMM_U;
        dec.alu_src    = 1'b1;
        dec.alu_pc     = 1'b1;
      end
      OP_NOP:    dec.is_nop = 1'b1;
      OP_SYSTEM: dec.is_nop = 1'b0;
      default:   dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: 3-5 cycles per instruction (+MUL_CYCLES for M ops), stalls on mem_ready_i/trap_ack_i.
// Outputs are combinational from state, latched opcode and mem_ready_i; reset blanks every output.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES   = 4,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [6:0] funct7_i,
  input  logic       mem_ready_i,
  input  logic       trap_ack_i,
  output logic [2:0] alu_op_o,
  output logic [2:0] imm_select_o,
  output logic       alu_src_o,
  output logic       alu_pc_o,
  output logic       add_sum_reg_o,
  output logic       reg_write_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       mem_to_reg_o,
  output logic       branch_o,
  output logic       trap_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       mul_busy_o,
  output logic [2:0] state_o
);

  localparam logic [7:0] CNT_INIT = (MUL_CYCLES > 0) ? 8'(MUL_CYCLES - 1) : 8'd0;

  state_e     state;
  logic [6:0] op_q;
  logic [6:0] f7_q;
  logic [7:0] cnt;
  dec_t       dec;
  logic       is_m_op;

  opcode_decoder u_dec (
    .op  (op_q),
    .dec (dec)
  );

  assign is_m_op = (op_i == OP_R) && (funct7_i == F7_MULDIV);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_FETCH;
      op_q  <= '0;
      f7_q  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready_i) state <= S_DECODE;
        S_DECODE: begin
          op_q <= op_i;
          f7_q <= funct7_i;
          if (op_i == OP_SYSTEM) begin
            state <= S_TRAP;
          end else if (is_m_op) begin
            if (MUL_CYCLES == 0) begin
              state <= S_TRAP;
            end else begin
              state <= S_MULDIV;
              cnt   <= CNT_INIT;
            end
          end else if (!is_known_op(op_i) && TRAP_ILLEGAL) begin
            state <= S_TRAP;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec.is_load || dec.is_store)                         state <= S_MEM;
          else if (dec.is_branch || dec.is_nop || dec.is_illegal) state <= S_FETCH;
          else                                                     state <= S_WB;
        end
        S_MEM: if (mem_ready_i) state <= dec.is_load ? S_WB : S_FETCH;
        S_WB:  state <= S_FETCH;
        // Counter starts at MUL_CYCLES-1, so exit happens on the MUL_CYCLES-th cycle
        S_MULDIV: begin
          if (cnt == 8'd0) state <= S_WB;
          else             cnt   <= cnt - 8'd1;
        end
        S_TRAP:  if (trap_ack_i) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op_o      = '0;
    imm_select_o  = '0;
    alu_src_o     = 1'b0;
    alu_pc_o      = 1'b0;
    add_sum_reg_o = 1'b0;
    reg_write_o   = 1'b0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = 1'b0;
    mem_to_reg_o  = 1'b0;
    branch_o      = 1'b0;
    trap_o        = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    mul_busy_o    = 1'b0;
    state_o       = rst_i ? S_FETCH : state;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          mem_rd_o   = 1'b1;
          ir_write_o = mem_ready_i;
        end
        S_EXEC: begin
          alu_op_o      = dec.alu_op;
          imm_select_o  = dec.imm_select;
          alu_src_o     = dec.alu_src;
          alu_pc_o      = dec.alu_pc;
          add_sum_reg_o = dec.add_sum_reg;
          branch_o      = dec.is_branch | dec.is_jump;
          pc_write_o    = dec.is_branch | dec.is_nop | dec.is_illegal;
        end
        S_MEM: begin
          alu_op_o      = dec.alu_op;
          imm_select_o  = dec.imm_select;
          alu_src_o     = dec.alu_src;
          alu_pc_o      = dec.alu_pc;
          add_sum_reg_o = dec.add_sum_reg;
          mem_rd_o      = dec.is_load;
          mem_wr_o      = dec.is_store;
          pc_write_o    = dec.is_store & mem_ready_i;
        end
        S_WB: begin
          reg_write_o  = 1'b1;
          pc_write_o   = 1'b1;
          branch_o     = dec.is_jump;
          mem_to_reg_o = dec.is_load;
        end
        S_MULDIV: begin
          alu_op_o   = ALU_R;
          mul_busy_o = (f7_q == F7_MULDIV);
        end
        // The handler owns the PC, so leaving TRAP never pulses pc_write_o
        S_TRAP:  trap_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
